// File: rtl/csc_mac_stream_if.sv
// Pixel component stream in, converted triple stream out, plus bank select and resync flag.
// The master side drives beats and downstream ready; the slave side is the converter.
interface csc_mac_stream_if #(
    parameter int DW = 8
);
    logic          mode;
    logic          in_val;
    logic          in_rdy;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          out_val;
    logic          out_rdy;
    logic [DW-1:0] out_c0;
    logic [DW-1:0] out_c1;
    logic [DW-1:0] out_c2;
    logic [2:0]    out_sat;
    logic          resync;

    modport master (
        output mode, in_val, in_sof, in_data, out_rdy,
        input  in_rdy, out_val, out_c0, out_c1, out_c2, out_sat, resync
    );

    modport slave (
        input  mode, in_val, in_sof, in_data, out_rdy,
        output in_rdy, out_val, out_c0, out_c1, out_c2, out_sat, resync
    );
endinterface

// File: rtl/csc_mac_stream.sv
// Three-lane MAC colour-space converter over a serial 3-component stream, two coefficient banks.
// Triple valid 1 clock after the third beat; only the third beat stalls, and only while a triple waits.
module csc_mac_stream #(
    parameter int DW   = 8,
    parameter int CW   = 16,
    parameter int FRAC = 13,
    parameter int AW   = 32,
    parameter logic [9*CW-1:0] COEF0 = {16'h0000, 16'h4093, 16'h253f,
                                        16'he5fc, 16'hf37d, 16'h253f,
                                        16'h3312, 16'h0000, 16'h253f},
    parameter logic [3*AW-1:0] OFF0  = {32'hFFDD6248, 32'h0010EF8C, 32'hFFE422CC},
    parameter logic [9*CW-1:0] COEF1 = {16'hFDBA, 16'hF439, 16'h0E0C,
                                        16'h0E0C, 16'hF6B0, 16'hFB44,
                                        16'h0323, 16'h1021, 16'h0839},
    parameter logic [3*AW-1:0] OFF1  = {32'h00101000, 32'h00101000, 32'h00021000}
) (
    input  logic               clk,
    input  logic               reset_n,
    csc_mac_stream_if.slave    bus
);
    localparam logic signed [AW-1:0] MAXV = AW'((1 << DW) - 1);

    logic [1:0]              phase_q, phase_d;
    logic                    mode_q, mode_d;
    logic signed [AW-1:0]    acc_q [3];
    logic signed [AW-1:0]    acc_d [3];
    logic                    out_val_q, out_val_d;
    logic [DW-1:0]           out_q [3];
    logic [DW-1:0]           out_d [3];
    logic [2:0]              sat_q, sat_d;
    logic                    resync_q, resync_d;

    logic                    accept;
    logic                    bank;
    logic [1:0]              eff_phase;
    logic signed [AW-1:0]    din_x;
    logic signed [AW-1:0]    coef_x [3];
    logic signed [AW-1:0]    prod [3];
    logic signed [AW-1:0]    off_x [3];
    logic signed [AW-1:0]    sum [3];
    logic signed [AW-1:0]    res [3];
    logic [DW-1:0]           clamp [3];
    logic [2:0]              clamp_f;

    assign bus.in_rdy = !(phase_q == 2'd2 && out_val_q && !bus.out_rdy);
    assign accept     = bus.in_val && bus.in_rdy;
    // SOF forces the beat into phase 0, so a partial pixel is simply overwritten
    assign eff_phase  = bus.in_sof ? 2'd0 : phase_q;
    assign bank       = (eff_phase == 2'd0) ? bus.mode : mode_q;
    assign din_x      = AW'($signed({1'b0, bus.in_data}));

    always_comb begin
        clamp_f = '0;
        for (int k = 0; k < 3; k++) begin
            coef_x[k] = AW'($signed(bank ? COEF1[(k*3 + int'(eff_phase))*CW +: CW]
                                         : COEF0[(k*3 + int'(eff_phase))*CW +: CW]));
            off_x[k]  = $signed(bank ? OFF1[k*AW +: AW] : OFF0[k*AW +: AW]);
            prod[k]   = din_x * coef_x[k];
            sum[k]    = acc_q[k] + prod[k] + off_x[k];
            res[k]    = sum[k] >>> FRAC;
            clamp[k]  = res[k][DW-1:0];
            if (res[k] < 0) begin
                clamp[k]   = '0;
                clamp_f[k] = 1'b1;
            end else if (res[k] > MAXV) begin
                clamp[k]   = '1;
                clamp_f[k] = 1'b1;
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        out_val_d = out_val_q && !bus.out_rdy;
        out_d     = out_q;
        sat_d     = sat_q;
        resync_d  = accept && bus.in_sof && (phase_q != 2'd0);
        if (accept) begin
            case (eff_phase)
                2'd0: begin
                    acc_d   = prod;
                    mode_d  = bus.mode;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    for (int k = 0; k < 3; k++) acc_d[k] = acc_q[k] + prod[k];
                    phase_d = 2'd2;
                end
                default: begin
                    phase_d   = 2'd0;
                    out_val_d = 1'b1;
                    out_d     = clamp;
                    sat_d     = clamp_f;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q   <= 2'd0;
            mode_q    <= 1'b0;
            out_val_q <= 1'b0;
            sat_q     <= '0;
            resync_q  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            out_val_q <= out_val_d;
            sat_q     <= sat_d;
            resync_q  <= resync_d;
            for (int k = 0; k < 3; k++) begin
                acc_q[k] <= acc_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    assign bus.out_val = out_val_q;
    assign bus.out_c0  = out_q[0];
    assign bus.out_c1  = out_q[1];
    assign bus.out_c2  = out_q[2];
    assign bus.out_sat = sat_q;
    assign bus.resync  = resync_q;
endmodule

// File: tb/tb_csc_mac_stream.sv
// Randomised and directed stimulus against a queue-based pixel model of the converter.
module tb_csc_mac_stream;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    csc_mac_stream_if #(.DW(8)) bus ();
    csc_mac_stream dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        int c [3];
        int sat;
    } trip_t;

    int    n_chk = 0;
    int    n_pass = 0;
    int    part_q [$];
    bit    part_mode;
    trip_t exp_q [$];
    bit    resync_exp = 1'b0;
    bit    ordy_g = 1'b1;

    int coef_tab [2][9] = '{'{9535, 0, 13074, 9535, -3203, -6660, 9535, 16531, 0},
                            '{2105, 4129, 803, -1212, -2384, 3596, 3596, -3015, -582}};
    longint off_tab [2][3] = '{'{-1826100, 1109900, -2268600},
                               '{135168, 1052672, 1052672}};

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic trip_t ref_csc(input bit b, input int a0, input int a1, input int a2);
        trip_t  t;
        longint s;
        longint r;
        t.sat = 0;
        for (int k = 0; k < 3; k++) begin
            s = longint'(coef_tab[b][k*3]) * a0 + longint'(coef_tab[b][k*3+1]) * a1
              + longint'(coef_tab[b][k*3+2]) * a2 + off_tab[b][k];
            r = s >>> 13;
            if (r < 0) begin
                t.c[k] = 0;   t.sat |= (1 << k);
            end else if (r > 255) begin
                t.c[k] = 255; t.sat |= (1 << k);
            end else t.c[k] = int'(r);
        end
        return t;
    endfunction

    // One clock: drive at negedge, check registered state, then advance the model for the coming edge.
    task automatic cycle(input bit v, input bit sof, input logic [7:0] d, input bit m,
                         input bit ordy, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        bus.in_val  = v;
        bus.in_sof  = sof;
        bus.in_data = d;
        bus.mode    = m;
        bus.out_rdy = ordy;
        #1;
        chk_eq("out_val", bus.out_val, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk_eq("out_c0", bus.out_c0, exp_q[0].c[0]);
            chk_eq("out_c1", bus.out_c1, exp_q[0].c[1]);
            chk_eq("out_c2", bus.out_c2, exp_q[0].c[2]);
            chk_eq("out_sat", bus.out_sat, exp_q[0].sat);
        end
        chk_eq("resync", bus.resync, resync_exp);
        exp_rdy = !(part_q.size() == 2 && exp_q.size() > 0 && !ordy);
        chk_eq("in_rdy", bus.in_rdy, exp_rdy);
        acc = v && bus.in_rdy;
        if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
        resync_exp = 1'b0;
        if (acc) begin
            if (sof) begin
                resync_exp = part_q.size() != 0;
                part_q.delete();
            end
            if (part_q.size() == 0) part_mode = m;
            part_q.push_back(int'(d));
            if (part_q.size() == 3) begin
                exp_q.push_back(ref_csc(part_mode, part_q[0], part_q[1], part_q[2]));
                part_q.delete();
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sof, input bit m);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, sof, d, m, ordy_g, acc);
            n++;
        end
        if (!acc) chk_eq("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0, ordy_g, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_sof  = 1'b0;
        bus.out_rdy = 1'b0;
        part_q.delete();
        exp_q.delete();
        resync_exp  = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("rst_out_val", bus.out_val, 0);
        chk_eq("rst_out_c0", bus.out_c0, 0);
        chk_eq("rst_out_c1", bus.out_c1, 0);
        chk_eq("rst_out_c2", bus.out_c2, 0);
        chk_eq("rst_out_sat", bus.out_sat, 0);
        chk_eq("rst_resync", bus.resync, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        bit acc;
        bus.mode = 1'b0; bus.in_val = 1'b0; bus.in_sof = 1'b0;
        bus.in_data = '0; bus.out_rdy = 1'b0;
        do_reset();

        ordy_g = 1'b1;
        send(8'd235, 1'b1, 1'b0); send(8'd128, 1'b0, 1'b0); send(8'd128, 1'b0, 1'b0);
        idle(2);
        send(8'd16, 1'b1, 1'b0);  send(8'd128, 1'b0, 1'b0); send(8'd128, 1'b0, 1'b0);
        send(8'd255, 1'b1, 1'b0); send(8'd128, 1'b0, 1'b0); send(8'd255, 1'b0, 1'b0);
        idle(2);

        // Bank 1 with a mode toggle mid-pixel; the triple is held so constants can be checked
        ordy_g = 1'b0;
        send(8'd255, 1'b1, 1'b1); send(8'd255, 1'b0, 1'b0); send(8'd255, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, acc);
        chk_eq("m1_c0", bus.out_c0, 235);
        chk_eq("m1_c1", bus.out_c1, 128);
        chk_eq("m1_c2", bus.out_c2, 128);
        chk_eq("m1_sat", bus.out_sat, 0);

        // Backpressure: triple above pending, next pixel streams until its third beat
        send(8'd60, 1'b1, 1'b0); send(8'd90, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'd200, 1'b0, 1'b0, acc);
            chk_eq("bp_block", acc, 0);
        end
        cycle(1'b1, 1'b0, 8'd200, 1'b0, 1'b1, acc);
        chk_eq("bp_release", acc, 1);
        ordy_g = 1'b1;
        idle(2);

        // Resync: partial pixel abandoned by a new SOF
        send(8'd10, 1'b1, 1'b0); send(8'd20, 1'b0, 1'b0);
        send(8'd235, 1'b1, 1'b0); send(8'd128, 1'b0, 1'b0); send(8'd128, 1'b0, 1'b0);
        idle(2);

        // Reset mid-pixel, then a clean pixel without SOF
        send(8'd50, 1'b1, 1'b0); send(8'd60, 1'b0, 1'b0);
        do_reset();
        send(8'd235, 1'b0, 1'b0); send(8'd128, 1'b0, 1'b0); send(8'd128, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 8) == 0, 8'($urandom),
                  1'($urandom), ($urandom % 3) != 0, acc);
        end
        ordy_g = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
